cozy_flag_unit: RTL and testbench

// - Produces and holds the cozy CPU condition flags {Z,N,C} that the branch

---
 rtl/cozy_flag_unit.sv | 103 ++++++++++
 tb/tb_cozy_flag_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cozy_flag_unit.sv
// Condition-flag register {Z,N,C} with an IRQ save/restore stack of flag words.
// Optional macro COZY_FLAGS_EXT_CHAIN_EN makes alu_ext chain Z across multi-word ops.
module cozy_flag_unit #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic             alu_ext,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             flags_load,
  input  logic [2:0]       flags_wdata,
  input  logic             irq_save,
  input  logic             irq_restore,
  input  logic             err_clr,
  output logic [2:0]       flags,
  output logic [2:0]       flags_next,
  output logic [4:0]       depth,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             err_conflict
);

  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [2:0]    stack_mem [STACK_DEPTH];
  logic [2:0]    flags_reg;
  logic [4:0]    depth_reg;
  logic          err_overflow_reg, err_underflow_reg, err_conflict_reg;

  logic          conflict, do_push, do_pop;
  logic          res_zero, z_alu;
  logic [2:0]    alu_flags;
  logic [PW-1:0] top_idx, push_idx;

  assign stack_full  = (depth_reg == 5'(STACK_DEPTH));
  assign stack_empty = (depth_reg == 5'd0);

  // Simultaneous save and restore cancel each other; the stack is left alone.
  assign conflict = irq_save & irq_restore;
  assign do_push  = irq_save & ~irq_restore & ~stack_full;
  assign do_pop   = irq_restore & ~irq_save & ~stack_empty;

  assign top_idx  = PW'(depth_reg - 5'd1);
  assign push_idx = PW'(depth_reg);

  assign res_zero = (alu_result == '0);
`ifdef COZY_FLAGS_EXT_CHAIN_EN
  assign z_alu = alu_ext ? (flags_reg[2] & res_zero) : res_zero;
`else
  logic unused_alu_ext;
  assign unused_alu_ext = alu_ext;
  assign z_alu = res_zero;
`endif
  assign alu_flags = {z_alu, alu_result[WIDTH-1], alu_carry};

  always_comb begin
    flags_next = flags_reg;
    if (do_pop)
      flags_next = stack_mem[top_idx];
    else if (flags_load)
      flags_next = flags_wdata;
    else if (alu_valid)
      flags_next = alu_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg         <= 3'b000;
      depth_reg         <= 5'd0;
      err_overflow_reg  <= 1'b0;
      err_underflow_reg <= 1'b0;
      err_conflict_reg  <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      if (do_push)
        depth_reg <= depth_reg + 5'd1;
      else if (do_pop)
        depth_reg <= depth_reg - 5'd1;
      // A new error event in the same cycle as err_clr keeps its bit set.
      err_overflow_reg  <= (err_overflow_reg  & ~err_clr) | (irq_save & ~irq_restore & stack_full);
      err_underflow_reg <= (err_underflow_reg & ~err_clr) | (irq_restore & ~irq_save & stack_empty);
      err_conflict_reg  <= (err_conflict_reg  & ~err_clr) | conflict;
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (do_push)
      stack_mem[push_idx] <= flags_reg;
  end

  assign flags         = flags_reg;
  assign depth         = depth_reg;
  assign err_overflow  = err_overflow_reg;
  assign err_underflow = err_underflow_reg;
  assign err_conflict  = err_conflict_reg;

endmodule

// File: tb/tb_cozy_flag_unit.sv
// Directed self-checking bench for cozy_flag_unit (default WIDTH=16, STACK_DEPTH=4).
module tb_cozy_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ext, alu_carry;
  logic [15:0] alu_result;
  logic        flags_load;
  logic [2:0]  flags_wdata;
  logic        irq_save, irq_restore, err_clr;
  logic [2:0]  flags, flags_next;
  logic [4:0]  depth;
  logic        stack_full, stack_empty;
  logic        err_overflow, err_underflow, err_conflict;

  int vectors = 0;
  int miscompares = 0;

  cozy_flag_unit dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ext(alu_ext), .alu_result(alu_result), .alu_carry(alu_carry),
    .flags_load(flags_load), .flags_wdata(flags_wdata),
    .irq_save(irq_save), .irq_restore(irq_restore), .err_clr(err_clr),
    .flags(flags), .flags_next(flags_next), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_conflict(err_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_ext = 0; alu_result = 16'h0; alu_carry = 0;
    flags_load = 0; flags_wdata = 3'b000;
    irq_save = 0; irq_restore = 0; err_clr = 0;
  endtask

  // Clock edge, then sample 1 ns later and drop all strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic alu(input logic [15:0] r, input logic c, input logic e);
    alu_valid = 1; alu_result = r; alu_carry = c; alu_ext = e;
  endtask

  task automatic load(input logic [2:0] v);
    flags_load = 1; flags_wdata = v;
  endtask

  initial begin
    idle();
    rst_n = 1;
    #2 rst_n = 0;
    #2;
    chk("rst_flags", 5'(flags), 5'b000);
    chk("rst_depth", depth, 5'd0);
    chk("rst_empty_full", {3'b0, stack_empty, stack_full}, 5'b00010);
    chk("rst_errs", {2'b0, err_overflow, err_underflow, err_conflict}, 5'b0);
    @(posedge clk); #1 rst_n = 1;

    // ALU update and latency
    alu(16'h0000, 1'b1, 1'b0); #1;
    chk("alu0_next", 5'(flags_next), 5'b101);
    chk("alu0_hold", 5'(flags), 5'b000);
    tick();
    chk("alu0_flags", 5'(flags), 5'b101);
    alu(16'h8001, 1'b0, 1'b0); tick();
    chk("alu8001_flags", 5'(flags), 5'b010);

    // Z chaining
    alu(16'h0000, 1'b0, 1'b0); tick();
    alu(16'h0001, 1'b0, 1'b1); tick();
    chk("chain_z0", 5'(flags), 5'b000);
    alu(16'h0000, 1'b0, 1'b0); tick();
    alu(16'h0000, 1'b0, 1'b1); tick();
    chk("chain_z1", 5'(flags), 5'b100);
    alu(16'h0005, 1'b0, 1'b0); tick();
    alu(16'h0000, 1'b0, 1'b1); tick();
`ifdef COZY_FLAGS_EXT_CHAIN_EN
    chk("chain_prevz0", 5'(flags), 5'b000);
`else
    chk("chain_prevz0", 5'(flags), 5'b100);
`endif

    // Nesting
    load(3'b001); tick();
    irq_save = 1; tick();
    chk("nest_depth1", depth, 5'd1);
    load(3'b100); tick();
    irq_save = 1; tick();
    load(3'b010); tick();
    chk("nest_depth2", depth, 5'd2);
    irq_restore = 1; #1;
    chk("nest_pop1_next", 5'(flags_next), 5'b100);
    tick();
    chk("nest_pop1", 5'(flags), 5'b100);
    irq_restore = 1; tick();
    chk("nest_pop2", 5'(flags), 5'b001);
    chk("nest_depth0", depth, 5'd0);

    // Async reset mid-IRQ with depth 2 and a pending error
    irq_restore = 1; tick();
    chk("pre_rst_underflow", 5'(err_underflow), 5'd1);
    irq_save = 1; tick();
    irq_save = 1; tick();
    chk("pre_rst_depth", depth, 5'd2);
    #2 rst_n = 0; #1;
    chk("mid_rst_flags", 5'(flags), 5'b000);
    chk("mid_rst_depth", depth, 5'd0);
    chk("mid_rst_empty", 5'(stack_empty), 5'd1);
    chk("mid_rst_errs", {2'b0, err_overflow, err_underflow, err_conflict}, 5'b0);
    @(posedge clk); #1 rst_n = 1;

    // Overflow / underflow
    load(3'b011); tick();
    for (int i = 0; i < 4; i++) begin
      irq_save = 1; tick();
    end
    chk("ovf_full_noerr", {3'b0, stack_full, err_overflow}, 5'b00010);
    irq_save = 1; tick();
    chk("ovf_depth", depth, 5'd4);
    chk("ovf_err", 5'(err_overflow), 5'd1);
    load(3'b000); tick();
    for (int i = 0; i < 5; i++) begin
      irq_restore = 1; tick();
    end
    chk("udf_depth", depth, 5'd0);
    chk("udf_flags", 5'(flags), 5'b011);
    chk("udf_errs", {3'b0, err_overflow, err_underflow}, 5'b00011);
    irq_restore = 1; err_clr = 1; tick();
    chk("clr_vs_event", {3'b0, err_overflow, err_underflow}, 5'b00001);
    err_clr = 1; tick();
    chk("clr_errs", {2'b0, err_overflow, err_underflow, err_conflict}, 5'b0);

    // Collisions
    load(3'b010); tick();
    irq_save = 1; tick();
    load(3'b000); tick();
    irq_restore = 1; load(3'b111); #1;
    chk("coll_rl_next", 5'(flags_next), 5'b010);
    tick();
    chk("coll_rl_flags", 5'(flags), 5'b010);
    chk("coll_rl_depth", depth, 5'd0);
    load(3'b011); tick();
    irq_save = 1; alu(16'h0000, 1'b1, 1'b0); tick();
    chk("coll_sa_flags", 5'(flags), 5'b101);
    chk("coll_sa_depth", depth, 5'd1);
    irq_restore = 1; tick();
    chk("coll_sa_pushed", 5'(flags), 5'b011);
    irq_save = 1; tick();
    irq_save = 1; irq_restore = 1; load(3'b110); tick();
    chk("coll_sr_depth", depth, 5'd1);
    chk("coll_sr_err", 5'(err_conflict), 5'd1);
    chk("coll_sr_flags", 5'(flags), 5'b110);
    chk("coll_sr_other_errs", {3'b0, err_overflow, err_underflow}, 5'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
